// File: rtl/gpr_pkg.sv
// Shared definitions for the GPR access controller: op codes, register
// indices and controller state encoding.
package gpr_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_RD  = 2'd1,
    OP_WR  = 2'd2,
    OP_RSW = 2'd3
  } op_e;

  localparam logic [3:0] REG_AX  = 4'd0;
  localparam logic [3:0] REG_BX  = 4'd1;
  localparam logic [3:0] REG_CX  = 4'd2;
  localparam logic [3:0] REG_DX  = 4'd3;
  localparam logic [3:0] REG_SI  = 4'd4;
  localparam logic [3:0] REG_DI  = 4'd5;
  localparam logic [3:0] REG_BP  = 4'd6;
  localparam logic [3:0] REG_SP  = 4'd7;
  localparam logic [3:0] REG_AX1 = 4'd8;
  localparam logic [3:0] REG_AX2 = 4'd9;
  localparam logic [3:0] REG_AX3 = 4'd10;
  localparam logic [3:0] REG_AX4 = 4'd11;
  localparam logic [3:0] REG_AX5 = 4'd12;
  localparam logic [3:0] REG_AX6 = 4'd13;
  localparam logic [3:0] REG_AX7 = 4'd14;
  localparam logic [3:0] REG_F   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/gpr_strobe_timer.sv
// Down-counter that times the GPR read strobe window; done_o marks the
// final cycle of the window.
module gpr_strobe_timer #(
  parameter int unsigned WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned CW = (WAIT > 1) ? $clog2(WAIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(WAIT - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/gpr_access_ctrl.sv
// Initiator-side GPR controller: accepts one RD/WR/RSW/NOP command, sequences
// the GPR rd/wr strobes and returns a response over a valid/ready channel.
module gpr_access_ctrl
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_W  = 14,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned RD_WAIT = 2,
  parameter bit          F_LOCK  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [REG_W-1:0]     req_dst,
  input  logic [3*REG_W-1:0]   req_src,
  input  logic [DATA_W-1:0]    req_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 rsp_err,
  output logic [ADDR_W-1:0]    gpr_address_in,
  output logic [ADDR_W-1:0]    gpr_address_out,
  output logic [DATA_W-1:0]    gpr_data_in,
  input  logic [DATA_W-1:0]    gpr_data_out,
  output logic                 gpr_rd,
  output logic                 gpr_wr
);

  localparam int unsigned SRC_PAD = ADDR_W - 3 * REG_W;
  localparam int unsigned DST_SHL = ADDR_W - REG_W;

  state_e              state_q, state_d;
  op_e                 op_q;
  op_e                 req_op_e;
  logic [REG_W-1:0]    dst_q;
  logic [ADDR_W-1:0]   addr_in_q;
  logic [ADDR_W-1:0]   addr_out_q;
  logic [DATA_W-1:0]   data_in_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_err_q;
  logic                accept;
  logic                lock_hit;
  logic                rd_done;
  logic                timer_load;

  assign req_op_e   = op_e'(req_op);
  assign accept     = req_valid && (state_q == ST_IDLE);
  assign lock_hit   = F_LOCK && (dst_q == REG_W'(REG_F));
  assign timer_load = accept && ((req_op_e == OP_RD) || (req_op_e == OP_RSW));

  gpr_strobe_timer #(
    .WAIT (RD_WAIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (timer_load),
    .en_i   (state_q == ST_READ),
    .done_o (rd_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          case (req_op_e)
            OP_NOP:  state_d = ST_RESP;
            OP_WR:   state_d = ST_WRITE;
            default: state_d = ST_READ;
          endcase
        end
      end
      ST_READ: begin
        if (rd_done) begin
          state_d = (op_q == OP_RSW) ? ST_WRITE : ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state so a reset edge drops them next cycle.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    gpr_rd    = (state_q == ST_READ);
    gpr_wr    = (state_q == ST_WRITE) && !lock_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_NOP;
      dst_q      <= '0;
      addr_in_q  <= '0;
      addr_out_q <= '0;
      data_in_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= req_op_e;
            dst_q      <= req_dst;
            addr_in_q  <= ADDR_W'(req_dst) << DST_SHL;
            addr_out_q <= ADDR_W'(req_src) << SRC_PAD;
            case (req_op_e)
              OP_NOP: rsp_data_q <= '0;
              OP_WR: begin
                rsp_data_q <= req_data;
                data_in_q  <= req_data;
              end
              default: ;
            endcase
          end
        end
        ST_READ: begin
          if (rd_done) begin
            rsp_data_q <= gpr_data_out;
            if (op_q == OP_RSW) begin
              data_in_q <= gpr_data_out;
            end
          end
        end
        ST_WRITE: rsp_err_q <= lock_hit;
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign gpr_address_in  = addr_in_q;
  assign gpr_address_out = addr_out_q;
  assign gpr_data_in     = data_in_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_err         = rsp_err_q;

endmodule

// File: tb/tb_gpr_access_ctrl.sv
// Self-checking bench for gpr_access_ctrl with a behavioural three-port-sum
// GPR model and a response scoreboard.
module tb_gpr_access_ctrl;

  localparam int unsigned DATA_W  = 14;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned RD_WAIT = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [1:0]           req_op = 2'd0;
  logic [REG_W-1:0]     req_dst = '0;
  logic [3*REG_W-1:0]   req_src = '0;
  logic [DATA_W-1:0]    req_data = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [DATA_W-1:0]    rsp_data;
  logic                 rsp_err;
  logic [ADDR_W-1:0]    gpr_address_in;
  logic [ADDR_W-1:0]    gpr_address_out;
  logic [DATA_W-1:0]    gpr_data_in;
  logic [DATA_W-1:0]    gpr_data_out;
  logic                 gpr_rd;
  logic                 gpr_wr;

  gpr_access_ctrl #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .REG_W   (REG_W),
    .RD_WAIT (RD_WAIT),
    .F_LOCK  (1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_dst         (req_dst),
    .req_src         (req_src),
    .req_data        (req_data),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_err         (rsp_err),
    .gpr_address_in  (gpr_address_in),
    .gpr_address_out (gpr_address_out),
    .gpr_data_in     (gpr_data_in),
    .gpr_data_out    (gpr_data_out),
    .gpr_rd          (gpr_rd),
    .gpr_wr          (gpr_wr)
  );

  always #5 clk = ~clk;

  // GPR model: combinational three-register sum, write on rising edge
  logic [DATA_W-1:0] regs [16] = '{default: '0};
  assign gpr_data_out = regs[gpr_address_out[11:8]] + regs[gpr_address_out[7:4]]
                      + regs[gpr_address_out[3:0]];
  always @(posedge clk) if (gpr_wr) regs[gpr_address_in[11:8]] <= gpr_data_in;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;
  rsp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] dst,
                         input logic [11:0] src, input logic [DATA_W-1:0] data,
                         input int hold);
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] wdata;
    logic              lock;
    rsp_t              e;
    rsp_t              p;
    int                exp_lat, exp_rd, exp_wr;
    int                lat, rd_cnt, wr_cnt;
    logic              got;
    sum   = regs[src[11:8]] + regs[src[7:4]] + regs[src[3:0]];
    lock  = (dst == 4'd15);
    wdata = (op == 2'd2) ? data : sum;
    case (op)
      2'd0: begin e.data = '0;   e.err = 1'b0; exp_lat = 1;           exp_rd = 0;       exp_wr = 0; end
      2'd1: begin e.data = sum;  e.err = 1'b0; exp_lat = RD_WAIT + 1; exp_rd = RD_WAIT; exp_wr = 0; end
      2'd2: begin e.data = data; e.err = lock; exp_lat = 2;           exp_rd = 0;       exp_wr = lock ? 0 : 1; end
      default: begin e.data = sum; e.err = lock; exp_lat = RD_WAIT + 2; exp_rd = RD_WAIT; exp_wr = lock ? 0 : 1; end
    endcase
    sb.push_back(e);

    @(negedge clk);
    check("idle_ready", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_dst   = dst;
    req_src   = src;
    req_data  = data;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; rd_cnt = 0; wr_cnt = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (i > 0) @(negedge clk);
      lat++;
      check("rd_wr_overlap", gpr_rd & gpr_wr, 0);
      if (gpr_rd) begin
        rd_cnt++;
        check("rd_addr", gpr_address_out, src);
      end
      if (gpr_wr) begin
        wr_cnt++;
        check("wr_addr", gpr_address_in, {dst, 8'h00});
        check("wr_data", gpr_data_in, wdata);
      end
      if (rsp_valid) got = 1'b1;
      else check("busy_ready", req_ready, 0);
    end
    check("rsp_seen", got, 1);
    check("latency", lat, exp_lat);
    check("rd_cycles", rd_cnt, exp_rd);
    check("wr_cycles", wr_cnt, exp_wr);
    if (got) begin
      for (int h = 0; h < hold; h++) begin
        check("bp_valid", rsp_valid, 1);
        check("bp_data", rsp_data, sb[0].data);
        check("bp_err", rsp_err, sb[0].err);
        check("bp_ready", req_ready, 0);
        @(negedge clk);
      end
      rsp_ready = 1'b1;
      p = sb.pop_front();
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data", rsp_data, p.data);
      check("rsp_err", rsp_err, p.err);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("post_ready", req_ready, 1);
      check("post_valid", rsp_valid, 0);
      check("post_err", rsp_err, 0);
      check("post_data_hold", rsp_data, p.data);
    end else begin
      p = sb.pop_front();
    end
  endtask

  task automatic reset_mid_rsw();
    logic [DATA_W-1:0] snap;
    snap = regs[9];
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'd3;
    req_dst   = 4'd9;
    req_src   = 12'h456;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_rd1", gpr_rd, 1);
    @(negedge clk);
    check("abort_rd2", gpr_rd, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_rd_drop", gpr_rd, 0);
    check("abort_ready", req_ready, 1);
    check("abort_data", rsp_data, 0);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_wr", gpr_wr, 0);
      check("abort_no_rsp", rsp_valid, 0);
      @(negedge clk);
    end
    check("abort_r9", regs[9], snap);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DATA_W-1:0] snap15;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", req_ready, 1);
    check("rst_valid", rsp_valid, 0);
    check("rst_rd", gpr_rd, 0);
    check("rst_wr", gpr_wr, 0);
    check("rst_ain", gpr_address_in, 0);
    check("rst_aout", gpr_address_out, 0);
    check("rst_din", gpr_data_in, 0);
    check("rst_data", rsp_data, 0);
    check("rst_err", rsp_err, 0);

    run_cmd(2'd2, 4'd0, 12'h000, 14'h3FFF, 0);
    run_cmd(2'd2, 4'd1, 12'h000, 14'd2, 0);
    run_cmd(2'd2, 4'd2, 12'h000, 14'd1, 0);
    run_cmd(2'd2, 4'd4, 12'h000, 14'd5, 0);
    run_cmd(2'd2, 4'd5, 12'h000, 14'd6, 0);
    run_cmd(2'd2, 4'd6, 12'h000, 14'd7, 0);

    run_cmd(2'd2, 4'd3, 12'h000, 14'h1A5, 0);
    check("r3_written", regs[3], 14'h1A5);

    run_cmd(2'd1, 4'd0, 12'h012, 14'h0, 0);

    run_cmd(2'd3, 4'd8, 12'h456, 14'h0, 0);
    check("r8_sum", regs[8], 14'd18);

    snap15 = regs[15];
    run_cmd(2'd2, 4'd15, 12'h000, 14'd1, 0);
    check("r15_locked", regs[15], snap15);

    run_cmd(2'd1, 4'd0, 12'h456, 14'h0, 5);
    run_cmd(2'd0, 4'd0, 12'h000, 14'h0, 1);
    run_cmd(2'd3, 4'd15, 12'h456, 14'h0, 2);
    check("r15_locked_rsw", regs[15], snap15);

    for (int n = 0; n < 8; n++) begin
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              12'($urandom), 14'($urandom), int'($urandom_range(0, 2)));
    end

    reset_mid_rsw();
    run_cmd(2'd1, 4'd0, 12'h456, 14'h0, 0);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpr_access_ctrl.md
Name: gpr_access_ctrl

Overview:
- Initiator-side controller for the general-purpose register file (GPR); owns the GPR's address_in, address_out, data_in, GPR_rd and GPR_wr inputs and consumes its data_out.
- Accepts one register-level command at a time over a valid/ready request channel: read, write, or read-sum-writeback.
- Sequences the rd and wr strobes, captures the three-operand sum, and returns a response over a valid/ready response channel.
- Sits between the CPU control unit and the GPR.

Parameters:
- DATA_W, 14, register and data width.
- ADDR_W, 12, GPR address bus width (three packed register-index fields).
- REG_W, 4, register-index field width.
- RD_WAIT, 2, cycles GPR_rd is held before data_out is sampled (min 1).
- F_LOCK, 1, when 1, writes to register index 15 (flags) are suppressed and flagged.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  controller idle, command accepted when valid&ready
- req_op  in  2  0=NOP, 1=RD, 2=WR, 3=RSW (read-sum-writeback)
- req_dst  in  REG_W  destination register index
- req_src  in  3*REG_W  packed source indices {a,b,c}, a in MSBs
- req_data  in  DATA_W  write data for WR
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_data  out  DATA_W  captured sum (RD/RSW); req_data echo (WR)
- rsp_err  out  1  write suppressed by F_LOCK
- gpr_address_in  out  ADDR_W  to GPR address_in; dst in top REG_W bits, rest zero
- gpr_address_out  out  ADDR_W  to GPR address_out; {a,b,c}, zero-extended at LSBs if ADDR_W > 3*REG_W
- gpr_data_in  out  DATA_W  to GPR data_in
- gpr_data_out  in  DATA_W  from GPR data_out
- gpr_rd  out  1  to GPR_rd
- gpr_wr  out  1  to GPR_wr

Behaviour:
- Reset (rst=1 at clk edge):
  - State returns to IDLE.
  - Outputs: req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, gpr_rd=0, gpr_wr=0, gpr_address_in=0, gpr_address_out=0, gpr_data_in=0.
  - Reset mid-command aborts it; a strobe asserted in the reset cycle drops the next cycle. No response is issued for an aborted command.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On valid&ready, latch op/dst/src/data.
  - NOP: go to RESP (rsp_data=0).
  - RD or RSW: go to READ.
  - WR: go to WRITE.
- READ:
  - gpr_rd=1 and gpr_address_out=src for exactly RD_WAIT cycles.
  - On the last cycle, capture gpr_data_out into rsp_data.
  - Then go to WRITE if RSW, else RESP.
- WRITE:
  - gpr_wr=1 for exactly one cycle; gpr_address_in=dst.
  - gpr_data_in = req_data (WR) or the captured sum (RSW).
  - If F_LOCK=1 and dst==15: gpr_wr stays 0 and rsp_err=1.
  - Then go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready, go to IDLE. rsp_err clears on the transition; rsp_data holds its last value.
- Strobe rules:
  - gpr_rd and gpr_wr are never high in the same cycle, because the GPR gives wr priority and would drop the read.
  - Addresses and data are registered and stable for the whole strobe window.
  - Strobes are low in IDLE and RESP.
- Latency, accept edge to rsp_valid=1:
  - NOP = 1.
  - WR = 2.
  - RD = RD_WAIT+1.
  - RSW = RD_WAIT+2.
- Throughput:
  - req_ready=0 from accept until the response handshake completes.
  - Back-to-back commands: the next accept is possible in the cycle after the rsp handshake.
- Arithmetic: the sum is computed inside the GPR, modulo 2^DATA_W. The controller does no arithmetic. A single-register read is issued as {a, z, z}, where z is a register the software keeps at 0.
- Unknown op values cannot occur (2-bit encoding fully decoded).

Decomposition:
- Shared package gpr_pkg:
  - Op codes OP_NOP, OP_RD, OP_WR, OP_RSW.
  - Register index constants REG_AX..REG_SP (0-7), REG_AX1..REG_AX7 (8-14), REG_F (15).
  - FSM state encoding.
- One sub-module, gpr_strobe_timer: a down-counter loaded with RD_WAIT that asserts done on its last cycle. Everything else is flat.

Test Plan:
- Reset then idle: rst held for 3 cycles -> req_ready=1, rsp_valid=0, gpr_rd=gpr_wr=0, all address and data outputs 0.
- WR: op=WR, dst=3, data=14'h1A5 -> gpr_wr=1 for exactly 1 cycle with gpr_address_in=12'h300 and gpr_data_in=14'h1A5; rsp_valid 2 cycles after accept; rsp_data=14'h1A5, rsp_err=0.
- RD with wrap: GPR model holds R0=14'h3FFF, R1=2, R2=1; op=RD, src={0,1,2} -> gpr_address_out=12'h012; gpr_rd high exactly 2 cycles; rsp_data=14'h0002 (mod 2^14); gpr_wr never asserted.
- RSW: R4=5, R5=6, R6=7; op=RSW, src={4,5,6}, dst=8 -> READ for 2 cycles, then gpr_wr for 1 cycle with address_in=12'h800 and data_in=18; rd/wr never overlap; rsp_data=18 after 4 cycles.
- F_LOCK: op=WR, dst=15, data=1 -> gpr_wr stays 0; rsp_err=1; R15 unchanged in the model.
- Backpressure and reset mid-op:
  - Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0.
  - Separately, assert rst in the second READ cycle of an RSW -> gpr_rd=0 the next cycle, no gpr_wr, no response, req_ready=1.
